// File: rtl/ttt_pkg.sv
// Shared definitions for the turn scheduler: cell encodings, FSM states,
// board size and the table of the eight winning lines.
// Cell code 2'b11 has no name here. It counts as occupied, so it blocks
// moves, and it never matches either player, so it never wins.
package ttt_pkg;

    localparam int N_CELLS = 9;
    localparam int N_LINES = 8;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_WRITE,
        S_SCAN,
        S_EVAL,
        S_OVER,
        S_CLEAR
    } state_e;

    // Row-major 3x3 board: three rows, three columns, two diagonals.
    localparam int LINE_TBL [N_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

endpackage

// File: rtl/turn_scheduler_win_eval.sv
// win_eval: purely combinational line checker.
//   board : shadow copy of all cells
//   win   : bit0 = P1 owns a full line, bit1 = P2 owns a full line
//   draw  : no winner and no empty cell left
// On a corrupt board both win bits can be set at the same time.
module win_eval
    import ttt_pkg::*;
#(
    parameter int CELLS = ttt_pkg::N_CELLS
) (
    input  logic [CELLS-1:0][1:0] board,
    output logic [1:0]            win,
    output logic                  draw
);

    logic any_empty;

    always_comb begin
        win       = 2'b00;
        any_empty = 1'b0;
        for (int l = 0; l < N_LINES; l++) begin
            if (board[LINE_TBL[l][0]] == CELL_P1 && board[LINE_TBL[l][1]] == CELL_P1 &&
                board[LINE_TBL[l][2]] == CELL_P1)
                win[0] = 1'b1;
            if (board[LINE_TBL[l][0]] == CELL_P2 && board[LINE_TBL[l][1]] == CELL_P2 &&
                board[LINE_TBL[l][2]] == CELL_P2)
                win[1] = 1'b1;
        end
        for (int c = 0; c < CELLS; c++) begin
            if (board[c] == CELL_EMPTY)
                any_empty = 1'b1;
        end
    end

    assign draw = (win == 2'b00) && !any_empty;

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: move sequencing for a two-player board game backed by an
// external cell store.
//   clk, btnCpuReset      : clock and async active-low reset
//   move_req, move_addr   : request to mark a cell for the current player
//   new_game              : clear the board and restart (wins over move_req)
//   rd_addr / rd_data     : cell-store read port (combinational read data)
//   wen, waddr, wd        : cell-store write port
//   player                : whose turn it is (0 = P1, 1 = P2)
//   busy                  : operation in progress (not IDLE and not OVER)
//   move_ack / move_rej   : one-cycle accept / refuse pulses
//   gameover, draw        : sticky result flags
// An accepted move probes the cell, writes it, rescans the whole store into
// a shadow board and evaluates it, so the store stays the single truth.
module turn_scheduler #(
    parameter int N_CELLS = ttt_pkg::N_CELLS,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              btnCpuReset,
    input  logic              move_req,
    input  logic [ADDR_W-1:0] move_addr,
    input  logic              new_game,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [1:0]        wd,
    output logic              player,
    output logic              busy,
    output logic              move_ack,
    output logic              move_rej,
    output logic [1:0]        gameover,
    output logic              draw
);
    import ttt_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_CELLS - 1);

    state_e                   state, state_nxt;
    logic [ADDR_W-1:0]        addr_q, cnt_q;
    logic                     player_q, draw_q, rej_q, rej_nxt;
    logic [1:0]               gameover_q;
    logic [N_CELLS-1:0][1:0]  shadow_q;
    logic [1:0]               eval_win;
    logic                     eval_draw;

    win_eval #(.CELLS(N_CELLS)) u_win_eval (
        .board (shadow_q),
        .win   (eval_win),
        .draw  (eval_draw)
    );

    always_comb begin
        state_nxt = state;
        move_ack  = 1'b0;
        rej_nxt   = 1'b0;
        wen       = 1'b0;
        waddr     = '0;
        wd        = CELL_EMPTY;
        rd_addr   = '0;
        busy      = (state != S_IDLE) && (state != S_OVER);
        case (state)
            S_IDLE: begin
                if (move_req) begin
                    if (32'(move_addr) >= N_CELLS) rej_nxt   = 1'b1;
                    else                           state_nxt = S_PROBE;
                end
            end
            S_PROBE: begin
                rd_addr = addr_q;
                // Ack is combinational so it lands one cycle after the request;
                // the refuse pulse is registered and lands one cycle later.
                if (rd_data == CELL_EMPTY) begin
                    move_ack  = 1'b1;
                    state_nxt = S_WRITE;
                end else begin
                    rej_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                wen       = 1'b1;
                waddr     = addr_q;
                wd        = player_q ? CELL_P2 : CELL_P1;
                state_nxt = S_SCAN;
            end
            S_SCAN: begin
                rd_addr = cnt_q;
                if (cnt_q == LAST) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                state_nxt = (eval_win != 2'b00 || eval_draw) ? S_OVER : S_IDLE;
            end
            S_OVER: state_nxt = S_OVER;
            S_CLEAR: begin
                wen   = 1'b1;
                waddr = cnt_q;
                if (cnt_q == LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // new_game aborts whatever is in flight, including a pending ack/rej.
        if (new_game && state != S_CLEAR) begin
            state_nxt = S_CLEAR;
            move_ack  = 1'b0;
            rej_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            player_q   <= 1'b0;
            gameover_q <= 2'b00;
            draw_q     <= 1'b0;
            rej_q      <= 1'b0;
            shadow_q   <= '0;
        end else begin
            state <= state_nxt;
            rej_q <= rej_nxt;
            // Counter runs only while staying in SCAN or CLEAR; any entry starts at 0.
            cnt_q <= (state_nxt == state && (state == S_SCAN || state == S_CLEAR)) ?
                     cnt_q + 1'b1 : '0;
            if (state == S_IDLE && state_nxt == S_PROBE)
                addr_q <= move_addr;
            if (state == S_SCAN)
                shadow_q[cnt_q] <= rd_data;
            if (state == S_EVAL && state_nxt != S_CLEAR) begin
                gameover_q <= gameover_q | eval_win;
                draw_q     <= draw_q | eval_draw;
                if (state_nxt == S_IDLE) player_q <= ~player_q;
            end
            if (state == S_CLEAR && state_nxt == S_IDLE) begin
                player_q   <= 1'b0;
                gameover_q <= 2'b00;
                draw_q     <= 1'b0;
                shadow_q   <= '0;
            end
        end
    end

    assign player   = player_q;
    assign move_rej = rej_q;
    assign gameover = gameover_q;
    assign draw     = draw_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a behavioural 16-entry cell store.
module tb_turn_scheduler;

    logic       clk = 1'b0;
    logic       btnCpuReset;
    logic       move_req, new_game;
    logic [3:0] move_addr;
    logic [3:0] rd_addr, waddr;
    logic [1:0] rd_data, wd, gameover;
    logic       wen, player, busy, move_ack, move_rej, draw;

    logic [1:0] mem [0:15];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (wen) mem[waddr] <= wd;
    assign rd_data = mem[rd_addr];

    turn_scheduler #(.N_CELLS(9), .ADDR_W(4)) dut (
        .clk(clk), .btnCpuReset(btnCpuReset), .move_req(move_req),
        .move_addr(move_addr), .new_game(new_game), .rd_addr(rd_addr),
        .rd_data(rd_data), .wen(wen), .waddr(waddr), .wd(wd),
        .player(player), .busy(busy), .move_ack(move_ack),
        .move_rej(move_rej), .gameover(gameover), .draw(draw)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accepted move; returns in the cycle where flags become valid (+13).
    task automatic play(input logic [3:0] a, input logic [1:0] exp_wd);
        tick; move_req = 1'b1; move_addr = a;
        @(negedge clk); chk("play_idle_busy", busy, 0);
        tick; move_req = 1'b0;
        @(negedge clk);
        chk("play_ack", move_ack, 1); chk("play_probe_addr", rd_addr, a);
        tick; @(negedge clk);
        chk("play_wen", wen, 1); chk("play_waddr", waddr, a); chk("play_wd", wd, exp_wd);
        for (int i = 0; i < 9; i++) begin
            tick;
            // A request during SCAN must be ignored (would otherwise be refused).
            if (i == 1) begin move_req = 1'b1; move_addr = 4'd15; end
            else move_req = 1'b0;
            @(negedge clk);
            chk("scan_rd_addr", rd_addr, i); chk("scan_wen", wen, 0);
            chk("scan_no_rej", move_rej, 0);
        end
        tick; @(negedge clk); chk("eval_busy", busy, 1);
        tick; @(negedge clk); chk("done_busy", busy, 0);
    endtask

    task automatic clear_body(input bit poke);
        for (int i = 0; i < 9; i++) begin
            tick; new_game = poke && (i == 3);
            @(negedge clk);
            chk("clr_wen", wen, 1); chk("clr_waddr", waddr, i);
            chk("clr_wd", wd, 0); chk("clr_busy", busy, 1);
        end
        tick; new_game = 1'b0;
        @(negedge clk);
        chk("clr_done_busy", busy, 0); chk("clr_done_wen", wen, 0);
        chk("clr_player", player, 0); chk("clr_gameover", gameover, 0);
        chk("clr_draw", draw, 0);
    endtask

    task automatic do_clear(input bit poke);
        tick; new_game = 1'b1;
        @(negedge clk);
        clear_body(poke);
    endtask

    task automatic req_silent(input logic [3:0] a);
        tick; move_req = 1'b1; move_addr = a;
        @(negedge clk);
        tick; move_req = 1'b0;
        @(negedge clk);
        chk("ign_ack", move_ack, 0); chk("ign_rej1", move_rej, 0); chk("ign_busy", busy, 0);
        tick; @(negedge clk);
        chk("ign_rej2", move_rej, 0); chk("ign_wen", wen, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 2'b11;
        btnCpuReset = 1'b0; move_req = 1'b0; new_game = 1'b0; move_addr = '0;
        #12;
        chk("rst_player", player, 0); chk("rst_gameover", gameover, 0);
        chk("rst_draw", draw, 0); chk("rst_wen", wen, 0); chk("rst_busy", busy, 0);
        chk("rst_ack", move_ack, 0); chk("rst_rej", move_rej, 0);
        chk("rst_rd_addr", rd_addr, 0); chk("rst_waddr", waddr, 0);
        #5 btnCpuReset = 1'b1;

        do_clear(0);
        for (int i = 0; i < 9; i++) chk("store_cleared", mem[i], 0);

        // P1 takes the centre.
        play(4'd4, 2'b01);
        chk("p1_move_player", player, 1); chk("p1_move_gameover", gameover, 0);
        chk("p1_move_draw", draw, 0); chk("store_cell4", mem[4], 2'b01);

        // P2 on an occupied cell: refused two cycles after the request.
        tick; move_req = 1'b1; move_addr = 4'd4;
        @(negedge clk);
        tick; move_req = 1'b0;
        @(negedge clk);
        chk("occ_ack", move_ack, 0); chk("occ_rej_early", move_rej, 0);
        chk("occ_probe_addr", rd_addr, 4);
        tick; @(negedge clk);
        chk("occ_rej", move_rej, 1); chk("occ_wen", wen, 0);
        tick; @(negedge clk);
        chk("occ_rej_pulse", move_rej, 0); chk("occ_busy", busy, 0);
        chk("occ_player", player, 1);

        // Out-of-range address refused the very next cycle, no probe.
        tick; move_req = 1'b1; move_addr = 4'd12;
        @(negedge clk);
        tick; move_req = 1'b0;
        @(negedge clk);
        chk("oor_rej", move_rej, 1); chk("oor_busy", busy, 0); chk("oor_rd_addr", rd_addr, 0);
        tick; @(negedge clk);
        chk("oor_rej_pulse", move_rej, 0); chk("oor_player", player, 1);

        // Clear with a stray new_game in the middle that must be ignored.
        do_clear(1);

        // P1 wins the top row.
        play(4'd0, 2'b01); chk("w1_player", player, 1);
        play(4'd3, 2'b10); chk("w2_player", player, 0);
        play(4'd1, 2'b01);
        play(4'd4, 2'b10); chk("w4_gameover", gameover, 0);
        play(4'd2, 2'b01);
        chk("win_gameover", gameover, 2'b01); chk("win_draw", draw, 0);
        chk("win_player", player, 0);
        req_silent(4'd5);
        chk("win_sticky", gameover, 2'b01);

        do_clear(0);

        // Full board, no line: X O X / X O O / O X X.
        play(4'd0, 2'b01); play(4'd1, 2'b10); play(4'd2, 2'b01);
        play(4'd4, 2'b10); play(4'd3, 2'b01); play(4'd5, 2'b10);
        play(4'd7, 2'b01); play(4'd6, 2'b10); play(4'd8, 2'b01);
        chk("draw_flag", draw, 1); chk("draw_gameover", gameover, 0);
        chk("draw_player", player, 0);
        req_silent(4'd0);
        chk("draw_sticky", draw, 1);

        do_clear(0);

        // Abort a move with new_game while the board is being scanned.
        play(4'd4, 2'b01); chk("ab_player", player, 1);
        tick; move_req = 1'b1; move_addr = 4'd0;
        @(negedge clk);
        tick; move_req = 1'b0;
        @(negedge clk); chk("ab_ack", move_ack, 1);
        tick; tick; tick;
        tick; new_game = 1'b1;
        @(negedge clk); chk("ab_scan_addr", rd_addr, 2);
        clear_body(0);
        for (int i = 0; i < 9; i++) chk("ab_store_cleared", mem[i], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
